// File: rtl/prefix_join_ctrl.sv
// Sequences one fast_prefix inner-join pass per spike/weight job and accumulates matched weights into a signed sum.
// Latency: ISSUE one cycle after accept; result two cycles after accept for an empty AND, else one cycle after pf_processing_done.
// Backpressure: one job in flight; in_ready low until the result handshakes. Optional PREFIX_JOIN_PERF_EN adds perf counters.
module prefix_join_ctrl #(
    parameter int BITMASK_WIDTH  = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int ACC_WIDTH      = 16,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 32,
    localparam int CNT_WIDTH     = $clog2(BITMASK_WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITMASK_WIDTH-1:0] in_spike_mask,
    input  logic [BITMASK_WIDTH-1:0] in_weight_mask,
    input  logic [ID_WIDTH-1:0]      in_id,
    output logic [BITMASK_WIDTH-1:0] pf_and_result,
    output logic [BITMASK_WIDTH-1:0] pf_bitmask_b,
    output logic                     pf_valid_match,
    input  logic                     pf_fast_valid,
    input  logic [WEIGHT_WIDTH-1:0]  pf_matched_weight,
    input  logic                     pf_processing_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_sum,
    output logic [CNT_WIDTH-1:0]     out_count,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic                     out_error
`ifdef PREFIX_JOIN_PERF_EN
    ,
    output logic [31:0]              perf_jobs,
    output logic [31:0]              perf_busy,
    output logic [15:0]              perf_errors
`endif
);

    localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_OUTPUT} state_t;

    state_t                   state, state_nxt;
    logic [BITMASK_WIDTH-1:0] and_q, wmask_q;
    logic [ID_WIDTH-1:0]      id_q;
    logic [CNT_WIDTH-1:0]     exp_q, cnt_q, cnt_nxt;
    logic [ACC_WIDTH-1:0]     sum_q, weight_sext;
    logic                     err_q;
    logic [TMO_WIDTH-1:0]     tmo_q;
    logic                     timeout_hit;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [BITMASK_WIDTH-1:0] m);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < BITMASK_WIDTH; i++) n = n + CNT_WIDTH'(m[i]);
        return n;
    endfunction

    assign weight_sext = {{(ACC_WIDTH-WEIGHT_WIDTH){pf_matched_weight[WEIGHT_WIDTH-1]}}, pf_matched_weight};
    assign cnt_nxt     = cnt_q + CNT_WIDTH'(pf_fast_valid);
    // Last permitted COLLECT cycle: the counter counts cycles already spent there.
    assign timeout_hit = (tmo_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (in_valid) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = (and_q == '0) ? S_OUTPUT : S_COLLECT;
            S_COLLECT: if (pf_processing_done || timeout_hit) state_nxt = S_OUTPUT;
            S_OUTPUT:  if (out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            and_q   <= '0;
            wmask_q <= '0;
            id_q    <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        and_q   <= in_spike_mask & in_weight_mask;
                        wmask_q <= in_weight_mask;
                        id_q    <= in_id;
                        exp_q   <= popcount(in_spike_mask & in_weight_mask);
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_ISSUE: tmo_q <= '0;
                S_COLLECT: begin
                    tmo_q <= tmo_q + TMO_WIDTH'(1);
                    if (pf_fast_valid) begin
                        sum_q <= sum_q + weight_sext;
                        cnt_q <= cnt_nxt;
                    end
                    // A match landing with done still counts toward the check.
                    if (pf_processing_done) err_q <= (cnt_nxt != exp_q);
                    else if (timeout_hit)   err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (state == S_IDLE);
    assign pf_valid_match = (state == S_ISSUE) && (and_q != '0);
    assign pf_and_result  = and_q;
    assign pf_bitmask_b   = wmask_q;
    assign out_valid      = (state == S_OUTPUT);
    assign out_sum        = sum_q;
    assign out_count      = cnt_q;
    assign out_id         = id_q;
    assign out_error      = err_q;

`ifdef PREFIX_JOIN_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_jobs   <= '0;
            perf_busy   <= '0;
            perf_errors <= '0;
        end else begin
            if (state != S_IDLE && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
            if (out_valid && out_ready) begin
                if (perf_jobs != '1)               perf_jobs   <= perf_jobs + 32'd1;
                if (err_q && perf_errors != '1)    perf_errors <= perf_errors + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prefix_join_ctrl.sv
// Bench for prefix_join_ctrl: a scripted fast_prefix stub plus a per-job reference model of sum, count, error and latency.
module tb_prefix_join_ctrl;

    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_spike_mask = '0;
    logic [7:0]  in_weight_mask = '0;
    logic [3:0]  in_id = '0;
    logic [7:0]  pf_and_result, pf_bitmask_b;
    logic        pf_valid_match;
    logic        pf_fast_valid = 1'b0;
    logic [7:0]  pf_matched_weight = '0;
    logic        pf_processing_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic [3:0]  out_count;
    logic [3:0]  out_id;
    logic        out_error;
`ifdef PREFIX_JOIN_PERF_EN
    logic [31:0] perf_jobs, perf_busy;
    logic [15:0] perf_errors;
`endif

    prefix_join_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_spike_mask(in_spike_mask), .in_weight_mask(in_weight_mask), .in_id(in_id),
        .pf_and_result(pf_and_result), .pf_bitmask_b(pf_bitmask_b), .pf_valid_match(pf_valid_match),
        .pf_fast_valid(pf_fast_valid), .pf_matched_weight(pf_matched_weight),
        .pf_processing_done(pf_processing_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_id(out_id), .out_error(out_error)
`ifdef PREFIX_JOIN_PERF_EN
        , .perf_jobs(perf_jobs), .perf_busy(perf_busy), .perf_errors(perf_errors)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  lat;
        logic [3:0]  pulses;
        logic [7:0]  andr;
        logic [7:0]  bmb;
        logic [15:0] sum;
        logic [3:0]  count;
        logic [3:0]  id;
        logic        err;
        logic        held_ok;
    } res_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] wq[$];
    logic       sch_v[64];
    logic [7:0] sch_w[64];
    logic       sch_d[64];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stub weights as in the fibre fetch: position+1 for each matched bit, LSB first.
    task automatic fibre_weights(input logic [7:0] a);
        wq.delete();
        for (int i = 0; i < 8; i++) if (a[i]) wq.push_back(8'(i + 1));
    endtask

    // mode 0: done with last weight, 1: done one cycle after last, 2: never done.
    task automatic build_sched(input int mode, input bit gaps);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            sch_v[i] = 1'b0; sch_w[i] = '0; sch_d[i] = 1'b0;
        end
        for (int i = 0; i < wq.size(); i++) begin
            if (gaps) c += int'($urandom_range(0, 1));
            sch_v[c] = 1'b1;
            sch_w[c] = wq[i];
            if (mode == 0 && i == wq.size() - 1) sch_d[c] = 1'b1;
            c++;
        end
        if (mode == 1 || (mode == 0 && wq.size() == 0)) sch_d[c] = 1'b1;
    endtask

    function automatic res_t model(input logic [7:0] sp, input logic [7:0] wm, input logic [3:0] id);
        res_t       e;
        int         s, n, done_at;
        logic [7:0] a;
        a = sp & wm;
        e = '0;
        e.andr = a; e.bmb = wm; e.id = id; e.held_ok = 1'b1;
        e.pulses = (a != 0) ? 4'd1 : 4'd0;
        if (a == 0) begin
            e.lat = 8'd2;
        end else begin
            s = 0; n = 0; done_at = -1;
            for (int c = 0; c < TMO; c++) begin
                if (sch_v[c]) begin s += int'($signed(sch_w[c])); n++; end
                if (sch_d[c]) begin done_at = c; break; end
            end
            e.sum   = s[15:0];
            e.count = n[3:0];
            if (done_at >= 0) begin
                e.lat = 8'(done_at + 3);
                e.err = (n != $countones(a));
            end else begin
                e.lat = 8'(TMO + 2);
                e.err = 1'b1;
            end
        end
        return e;
    endfunction

    // Plays one job through the DUT with the current schedule; hold = cycles out_ready stays low.
    task automatic run_job(input logic [7:0] sp, input logic [7:0] wm, input logic [3:0] id,
                           input int hold, output res_t o);
        int   cyc, idx, pulses;
        logic held_ok;
        res_t snap;
        o = '0; held_ok = 1'b1; pulses = 0;
        if (in_ready !== 1'b1) held_ok = 1'b0;
        in_valid = 1'b1; in_spike_mask = sp; in_weight_mask = wm; in_id = id;
        tick;
        in_valid = 1'b0;
        cyc = 1;
        o.andr = pf_and_result;
        o.bmb  = pf_bitmask_b;
        while (cyc < 60 && out_valid !== 1'b1) begin
            if (pf_valid_match === 1'b1) pulses++;
            if (in_ready !== 1'b0) held_ok = 1'b0;
            if (cyc >= 2 && pf_and_result !== o.andr) held_ok = 1'b0;
            if (cyc == 1) begin
                pf_fast_valid = 1'b1; pf_matched_weight = 8'($urandom); pf_processing_done = 1'b0;
            end else begin
                idx = cyc - 2;
                pf_fast_valid = sch_v[idx]; pf_matched_weight = sch_w[idx]; pf_processing_done = sch_d[idx];
            end
            tick;
            cyc++;
        end
        o.lat   = (out_valid === 1'b1) ? 8'(cyc) : 8'hFF;
        o.sum   = out_sum; o.count = out_count; o.id = out_id; o.err = out_error;
        snap = o;
        for (int h = 0; h < hold; h++) begin
            pf_fast_valid = 1'($urandom_range(0, 1)); pf_matched_weight = 8'($urandom);
            pf_processing_done = 1'($urandom_range(0, 1));
            in_valid = 1'b1; in_spike_mask = 8'($urandom); in_weight_mask = 8'($urandom); in_id = 4'($urandom);
            out_ready = 1'b0;
            if (pf_valid_match === 1'b1) pulses++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) held_ok = 1'b0;
            if (out_sum !== snap.sum || out_count !== snap.count || out_id !== snap.id || out_error !== snap.err)
                held_ok = 1'b0;
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) held_ok = 1'b0;
        tick;
        out_ready = 1'b0; pf_fast_valid = 1'b0; pf_processing_done = 1'b0;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) held_ok = 1'b0;
        o.pulses = 4'(pulses);
        o.held_ok = held_ok;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if ({pf_valid_match, pf_and_result, pf_bitmask_b} !== 17'h0) begin
            errors++; $display("FAIL reset_pf: got %b/%h/%h want 0/00/00", pf_valid_match, pf_and_result, pf_bitmask_b);
        end
        checks++;
        if ({out_valid, out_sum, out_count, out_id, out_error} !== 26'h0) begin
            errors++; $display("FAIL reset_out: got v=%b s=%h c=%0d id=%0d e=%b want all 0",
                               out_valid, out_sum, out_count, out_id, out_error);
        end
    endtask

    task automatic test_basic;
        res_t o, e;
        fibre_weights(8'b10101000);
        build_sched(0, 1'b0);
        e = model(8'b10101000, 8'b10101100, 4'd3);
        run_job(8'b10101000, 8'b10101100, 4'd3, 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL basic: got %p want %p", o, e); end
        checks++;
        if (o.sum !== 16'd18) begin errors++; $display("FAIL basic_sum: got %0d want 18", o.sum); end
    endtask

    task automatic test_empty;
        res_t o, e;
        wq.delete();
        build_sched(0, 1'b0);
        e = model(8'b00000011, 8'b10101100, 4'd9);
        run_job(8'b00000011, 8'b10101100, 4'd9, 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL empty: got %p want %p", o, e); end
    endtask

    task automatic test_signed_wrap;
        res_t o, e;
        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h02);
        build_sched(0, 1'b0);
        e = model(8'h03, 8'h03, 4'd1);
        run_job(8'h03, 8'h03, 4'd1, 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL signed_wrap: got %p want %p", o, e); end
        checks++;
        if (o.sum !== 16'h0001 || o.count !== 4'd2) begin
            errors++; $display("FAIL signed_wrap_sum: got %h/%0d want 0001/2", o.sum, o.count);
        end
    endtask

    task automatic test_back_to_back;
        res_t o, e;
        fibre_weights(8'b01100110);
        build_sched(1, 1'b1);
        e = model(8'b01101110, 8'b11100110, 4'd12);
        run_job(8'b01101110, 8'b11100110, 4'd12, 5, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL backpressure: got %p want %p", o, e); end
        fibre_weights(8'h81);
        build_sched(0, 1'b0);
        e = model(8'h81, 8'hC3, 4'd7);
        run_job(8'h81, 8'hC3, 4'd7, 2, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL back_to_back: got %p want %p", o, e); end
    endtask

    task automatic test_timeout;
        res_t o, e;
        fibre_weights(8'h07);
        build_sched(2, 1'b0);
        e = model(8'h07, 8'h07, 4'd2);
        run_job(8'h07, 8'h07, 4'd2, 1, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL timeout: got %p want %p", o, e); end
        checks++;
        if (o.lat !== 8'd34 || o.err !== 1'b1) begin
            errors++; $display("FAIL timeout_lat: got lat=%0d err=%b want 34/1", o.lat, o.err);
        end
    endtask

    task automatic test_count_mismatch;
        res_t o, e;
        wq.delete(); wq.push_back(8'd1);
        build_sched(0, 1'b0);
        e = model(8'h07, 8'h07, 4'd4);
        run_job(8'h07, 8'h07, 4'd4, 0, o);
        checks++;
        if (o !== e || o.err !== 1'b1 || o.count !== 4'd1) begin
            errors++; $display("FAIL count_mismatch: got %p want %p", o, e);
        end
    endtask

    task automatic test_mid_reset;
        res_t o, e;
        in_valid = 1'b1; in_spike_mask = 8'hFF; in_weight_mask = 8'hFF; in_id = 4'd5;
        tick;
        in_valid = 1'b0;
        tick;
        pf_fast_valid = 1'b1; pf_matched_weight = 8'h7F;
        tick; tick;
        rst = 1'b1; pf_fast_valid = 1'b0;
        tick;
        rst = 1'b0;
        checks++;
        if ({in_ready, pf_valid_match, pf_and_result, pf_bitmask_b, out_valid, out_sum, out_count, out_id, out_error}
            !== {1'b1, 43'h0}) begin
            errors++; $display("FAIL mid_reset: got rdy=%b pf=%b/%h/%h v=%b s=%h c=%0d id=%0d e=%b want 1 and all 0",
                               in_ready, pf_valid_match, pf_and_result, pf_bitmask_b,
                               out_valid, out_sum, out_count, out_id, out_error);
        end
        fibre_weights(8'h5A);
        build_sched(0, 1'b1);
        e = model(8'h5A, 8'h5A, 4'd6);
        run_job(8'h5A, 8'h5A, 4'd6, 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL after_reset: got %p want %p", o, e); end
    endtask

    task automatic test_random;
        res_t       o, e;
        logic [7:0] sp, wm;
        int         mode;
        for (int j = 0; j < 25; j++) begin
            sp = 8'($urandom); wm = 8'($urandom);
            mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) fibre_weights(sp & wm);
            else begin
                wq.delete();
                for (int k = 0; k < $countones(sp & wm); k++) wq.push_back(8'($urandom));
            end
            if (mode == 3) begin
                if (wq.size() > 0) void'(wq.pop_front());
                mode = 0;
            end
            build_sched(mode, 1'($urandom_range(0, 1)));
            e = model(sp, wm, 4'(j));
            run_job(sp, wm, 4'(j), int'($urandom_range(0, 3)), o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL random_%0d: got %p want %p", j, o, e); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_empty;
        test_signed_wrap;
        test_back_to_back;
        test_timeout;
        test_count_mismatch;
        test_mid_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prefix_join_ctrl.md
Name: prefix_join_ctrl

Overview:
Sequencer for the fast_prefix inner-join unit in the LoAS datapath. Accepts spike/weight bitmask jobs through a valid/ready handshake and computes the AND mask. It launches one fast_prefix pass per job and accumulates the serially returned matched weights into a signed partial sum. The result, match count and error flag are returned through a valid/ready output handshake. Sits between the fibre fetch stage and the PE accumulator.

Parameters:
BITMASK_WIDTH, 8, fibre length / bitmask width (matches fast_prefix)
WEIGHT_WIDTH, 8, width of matched_weight from fast_prefix; two's-complement
ACC_WIDTH, 16, partial-sum width; must be >= WEIGHT_WIDTH + clog2(BITMASK_WIDTH)
ID_WIDTH, 4, job tag width
TIMEOUT_CYCLES, 32, max cycles in COLLECT before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  job offered
in_ready  out  1  controller can accept job
in_spike_mask  in  BITMASK_WIDTH  bitmask A (spikes)
in_weight_mask  in  BITMASK_WIDTH  bitmask B (nonzero weights)
in_id  in  ID_WIDTH  job tag
pf_and_result  out  BITMASK_WIDTH  to fast_prefix and_result
pf_bitmask_b  out  BITMASK_WIDTH  to fast_prefix bitmask_b
pf_valid_match  out  1  one-cycle launch pulse to fast_prefix
pf_fast_valid  in  1  fast_prefix: matched_weight valid this cycle
pf_matched_weight  in  WEIGHT_WIDTH  fast_prefix matched weight
pf_processing_done  in  1  fast_prefix: pass complete
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sum  out  ACC_WIDTH  signed accumulated weight sum
out_count  out  clog2(BITMASK_WIDTH)+1  number of matches accumulated
out_id  out  ID_WIDTH  tag of job
out_error  out  1  timeout or count mismatch

Behaviour:
- Reset values, applied on any clk edge with rst=1, including mid-job:
  - State IDLE; in_ready=1.
  - pf_valid_match=0, pf_and_result=0, pf_bitmask_b=0.
  - out_valid=0, out_sum=0, out_count=0, out_id=0, out_error=0.
  - Timeout counter=0.
  - Any in-flight job is dropped; fast_prefix shares rst.
- States: IDLE, ISSUE, COLLECT, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_id, and_mask = spike&weight, in_weight_mask, and expected = popcount(and_mask).
  - Clear sum, count and error; go to ISSUE.
- ISSUE (one cycle):
  - pf_and_result=and_mask and pf_bitmask_b=weight_mask are registered and held stable from ISSUE until exit from COLLECT.
  - If and_mask==0: no pulse; go to OUTPUT with sum=0, count=0, error=0.
  - Else: pf_valid_match=1 for exactly this cycle; go to COLLECT.
- COLLECT:
  - Each cycle with pf_fast_valid=1: sum += sign-extended pf_matched_weight (wraps modulo 2^ACC_WIDTH); count++.
  - On pf_processing_done=1: go to OUTPUT. A pf_fast_valid asserted in the same cycle is still accumulated.
  - On entering OUTPUT from COLLECT: error = (count_final != expected).
  - Timeout counter increments each COLLECT cycle. If it reaches TIMEOUT_CYCLES without done, go to OUTPUT with error=1 and the partial sum and count.
  - pf_fast_valid outside COLLECT is ignored.
- OUTPUT:
  - out_valid=1; out_* held stable until out_valid&out_ready.
  - On handshake, return to IDLE.
  - in_ready=0 in every non-IDLE state; one job in flight at a time.
- Latency (accept edge = cycle 0):
  - ISSUE is cycle 1.
  - Empty AND: out_valid in cycle 2.
  - Otherwise: out_valid one cycle after the pf_processing_done cycle.
- A job is accepted in IDLE on the cycle after an output handshake. No same-cycle output-to-input overlap.

Optional Feature:
Macro PREFIX_JOIN_PERF_EN.
- Defined:
  - Adds outputs perf_jobs (32b, jobs completed), perf_busy (32b, cycles not in IDLE) and perf_errors (16b, jobs with out_error).
  - All three saturate at max, reset to 0 on rst, and increment on the output handshake or per busy cycle as named.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Setup: fast_prefix instance, fibre data = position+1. Job spike=8'b10101000, weight=8'b10101100, id=3 -> exactly one pf_valid_match pulse; pf_and_result=8'b10101000; out_sum=18 (8+6+4), out_count=3, out_id=3, out_error=0.
- Spike=8'b00000011, weight=8'b10101100 -> no pf_valid_match; out_valid in cycle 2 after accept; out_sum=0, out_count=0, out_error=0.
- Stub returning weights 8'hFF, 8'h02, then done -> out_sum=16'h0001, count=2. Done asserted together with the last fast_valid is still counted.
- out_ready held low 5 cycles in OUTPUT -> out_* stable, in_ready=0, new in_valid not accepted; accepted in IDLE after handshake.
- Stub never asserts done -> after 32 COLLECT cycles out_valid=1, out_error=1. Stub asserting done after 1 of 3 expected matches -> out_error=1, out_count=1.
- rst asserted for 1 cycle during COLLECT -> next cycle IDLE, in_ready=1, all outputs 0. A following job completes correctly.
